// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and codes for the multicycle RV32I control FSM.
// State encodings, opcode constants and datapath select codes.
package multicycle_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_imm_src_dec.sv
// Combinational opcode -> immediate format decoder; zero latency, no handshake.
module multicycle_ctrl_fsm_imm_src_dec
    import multicycle_ctrl_fsm_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [1:0] imm_src_o
);

    always_comb begin
        imm_src_o = IMM_I;
        case (op_i)
            OP_STORE:  imm_src_o = IMM_S;
            OP_BRANCH: imm_src_o = IMM_B;
            OP_JAL:    imm_src_o = IMM_J;
            default:   imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I main control FSM: Moore outputs per state, mem_ready gates
// FETCH/MEMREAD/MEMWRITE progress so slow memory simply stretches those states.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter logic [3:0] RESET_STATE    = 4'd0,
    parameter bit         STRICT_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       instr_retired,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= state_t'(RESET_STATE);
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        RegWrite      = 1'b0;
        ALUOp         = ALUOP_ADD;
        instr_retired = 1'b0;
        illegal_instr = 1'b0;
        if (reset) begin
            // Hold the FETCH mux settings with every enable quiet.
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            state_d   = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                    if (mem_ready) state_d = S_DECODE;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    case (op)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_RTYPE:          state_d = S_EXECUTER;
                        OP_ITYPE:          state_d = S_EXECUTEI;
                        OP_BRANCH:         state_d = S_BEQ;
                        OP_JAL:            state_d = S_JAL;
                        default:           state_d = STRICT_ILLEGAL ? S_ILLEGAL : S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    AdrSrc = 1'b1;
                    if (mem_ready) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    ResultSrc     = RES_DATA;
                    RegWrite      = 1'b1;
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end
                S_MEMWRITE: begin
                    AdrSrc        = 1'b1;
                    MemWrite      = 1'b1;
                    instr_retired = mem_ready;
                    if (mem_ready) state_d = S_FETCH;
                end
                S_EXECUTER: begin
                    ALUSrcA = SRCA_RS1;
                    ALUOp   = ALUOP_FUNCT;
                    state_d = S_ALUWB;
                end
                S_EXECUTEI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALUOP_FUNCT;
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite      = 1'b1;
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end
                S_BEQ: begin
                    ALUSrcA       = SRCA_RS1;
                    ALUOp         = ALUOP_SUB;
                    PCWrite       = zero;
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end
                S_JAL: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                    PCWrite = 1'b1;
                    state_d = S_ALUWB;
                end
                S_ILLEGAL: begin
                    illegal_instr = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    multicycle_ctrl_fsm_imm_src_dec u_imm_src_dec (
        .op_i      (op),
        .imm_src_o (ImmSrc)
    );

    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for the multicycle control FSM with hand-computed expectations.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic       instr_retired, illegal_instr;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_ctrl_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .AdrSrc        (AdrSrc),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .ResultSrc     (ResultSrc),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .RegWrite      (RegWrite),
        .ALUOp         (ALUOp),
        .ImmSrc        (ImmSrc),
        .instr_retired (instr_retired),
        .illegal_instr (illegal_instr),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Advance one edge and let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enables packed as {PCWrite, IRWrite, MemWrite, RegWrite}
    function automatic logic [3:0] en();
        return {PCWrite, IRWrite, MemWrite, RegWrite};
    endfunction

    initial begin
        reset = 1'b1; op = 7'b0110011; zero = 1'b0; mem_ready = 1'b1;
        tick();
        #1;
        check("rst_state", state_dbg, 4'd0);
        check("rst_enables", en(), 4'b0000);
        check("rst_retired", instr_retired, 1'b0);
        check("rst_srcb", ALUSrcB, 2'b10);
        check("rst_ressrc", ResultSrc, 2'b10);

        // R-type add, mem_ready=1: 0,1,6,8
        reset = 1'b0; #1;
        check("r_fetch_state", state_dbg, 4'd0);
        check("r_fetch_en", en(), 4'b1100);
        tick();
        check("r_dec_state", state_dbg, 4'd1);
        check("r_dec_srcab", {ALUSrcA, ALUSrcB}, 4'b0101);
        tick();
        check("r_exe_state", state_dbg, 4'd6);
        check("r_exe_aluop", ALUOp, 2'b10);
        check("r_exe_regw", RegWrite, 1'b0);
        tick();
        check("r_wb_state", state_dbg, 4'd8);
        check("r_wb_regw_ret", {RegWrite, instr_retired}, 2'b11);
        tick();
        check("r_back_fetch", state_dbg, 4'd0);

        // lw with 3 stall cycles in MEMREAD
        op = 7'b0000011;
        tick(); tick();
        check("lw_memadr", state_dbg, 4'd2);
        check("lw_imm", ImmSrc, 2'b00);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("lw_stall_state", state_dbg, 4'd3);
            check("lw_stall_adr", AdrSrc, 1'b1);
            tick();
        end
        mem_ready = 1'b1; #1;
        check("lw_rd_state", state_dbg, 4'd3);
        check("lw_rd_adr", AdrSrc, 1'b1);
        tick();
        check("lw_wb_state", state_dbg, 4'd4);
        check("lw_wb_res", ResultSrc, 2'b01);
        check("lw_wb_regw_ret", {RegWrite, instr_retired}, 2'b11);
        tick();
        check("lw_back_fetch", state_dbg, 4'd0);

        // beq taken then not taken
        op = 7'b1100011;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            tick(); tick();
            check("beq_state", state_dbg, 4'd9);
            check("beq_imm", ImmSrc, 2'b10);
            check("beq_aluop", ALUOp, 2'b01);
            check("beq_pcwrite", PCWrite, (k == 0) ? 1'b1 : 1'b0);
            check("beq_ret", instr_retired, 1'b1);
            tick();
            check("beq_back_fetch", state_dbg, 4'd0);
        end

        // sw with mem_ready delayed 2 cycles
        op = 7'b0100011; zero = 1'b0;
        tick(); tick();
        check("sw_memadr", state_dbg, 4'd2);
        check("sw_imm", ImmSrc, 2'b01);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin mem_ready = 1'b1; #1; end
            check("sw_state", state_dbg, 4'd5);
            check("sw_en", en(), 4'b0010);
            check("sw_ret", instr_retired, (i == 2) ? 1'b1 : 1'b0);
            tick();
        end
        check("sw_back_fetch", state_dbg, 4'd0);

        // reset during MEMWRITE with mem_ready=0
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        check("rmw_state", state_dbg, 4'd5);
        check("rmw_memw", MemWrite, 1'b1);
        reset = 1'b1; #1;
        check("rmw_forced_en", en(), 4'b0000);
        check("rmw_forced_ret", instr_retired, 1'b0);
        tick();
        reset = 1'b0; #1;
        check("rmw_fetch", state_dbg, 4'd0);
        check("rmw_memw_after", MemWrite, 1'b0);
        check("rmw_ret_after", instr_retired, 1'b0);

        // Illegal opcode parks the FSM until reset
        op = 7'b1111111; mem_ready = 1'b1;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            check("ill_state", state_dbg, 4'd15);
            check("ill_flag", illegal_instr, 1'b1);
            check("ill_en", {en(), instr_retired}, 5'b00000);
            tick();
        end
        reset = 1'b1;
        tick();
        check("ill_rst_state", state_dbg, 4'd0);
        check("ill_rst_flag", illegal_instr, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
